// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared types and constants for the RV32M iterative multiply /
//             divide unit and for the decode logic that steers M-type ops.
//  Contents : c_XLEN_DEFAULT   default operand / result width
//             c_FUNCT7_MULDIV  funct7 value identifying M-extension ops
//             muldiv_op_e      funct3 encodings of the eight M ops
//             muldiv_state_e   sequencer states
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    localparam int          c_XLEN_DEFAULT  = 32;
    localparam logic [6:0]  c_FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_if
//  Purpose  : Request / response bundle between the execute stage and the
//             multiply / divide unit.
//  Signals  : start_i   request, accepted only while ready_o = 1
//             funct3_i  M-extension op select
//             a_i, b_i  rs1 / rs2 operands
//             flush_i   kill in-flight operation
//             ready_o   unit idle
//             busy_o    operation in flight (pipeline stall)
//             done_o    one-cycle result-valid pulse
//             result_o  result word, held until next done_o
//  Modports : master (execute stage), slave (muldiv_unit)
//  Revision : 1.0  initial release
// ============================================================================
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = c_XLEN_DEFAULT
) ();

    logic             start_i;
    logic [2:0]       funct3_i;
    logic [XLEN-1:0]  a_i;
    logic [XLEN-1:0]  b_i;
    logic             flush_i;
    logic             ready_o;
    logic             busy_o;
    logic             done_o;
    logic [XLEN-1:0]  result_o;

    modport master (
        output start_i, funct3_i, a_i, b_i, flush_i,
        input  ready_o, busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, a_i, b_i, flush_i,
        output ready_o, busy_o, done_o, result_o
    );

endinterface : muldiv_if
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sign_fix
//  Purpose  : Combinational sign handling around the unsigned datapath.
//             Accept side: extracts operand signs and magnitudes according
//             to the signedness of the op.
//             Result side: applies sign correction to the raw unsigned
//             product / quotient / remainder and selects the result word.
//  Ports    : i_op, i_a, i_b           op and raw operands at accept
//             o_sign_a/b, o_mag_a/b    signs and magnitudes
//             i_res_op, i_res_sign_a/b latched op and signs
//             i_res_b_zero             divisor was zero
//             i_hi, i_lo               raw datapath halves
//             o_result                 final result word
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = c_XLEN_DEFAULT
) (
    input  muldiv_op_e        i_op,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic              o_sign_a,
    output logic              o_sign_b,
    output logic [XLEN-1:0]   o_mag_a,
    output logic [XLEN-1:0]   o_mag_b,
    input  muldiv_op_e        i_res_op,
    input  logic              i_res_sign_a,
    input  logic              i_res_sign_b,
    input  logic              i_res_b_zero,
    input  logic [XLEN-1:0]   i_hi,
    input  logic [XLEN-1:0]   i_lo,
    output logic [XLEN-1:0]   o_result
);

    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_neg;
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_fix;

    always_comb begin
        w_a_signed = (i_op == MUL) || (i_op == MULH) || (i_op == MULHSU) ||
                     (i_op == DIV) || (i_op == REM);
        w_b_signed = (i_op == MUL) || (i_op == MULH) ||
                     (i_op == DIV) || (i_op == REM);
        o_sign_a   = w_a_signed & i_a[XLEN-1];
        o_sign_b   = w_b_signed & i_b[XLEN-1];
        o_mag_a    = o_sign_a ? (-i_a) : i_a;
        o_mag_b    = o_sign_b ? (-i_b) : i_b;
    end

    always_comb begin
        w_neg      = i_res_sign_a ^ i_res_sign_b;
        w_prod     = {i_hi, i_lo};
        w_prod_fix = w_neg ? (-w_prod) : w_prod;
        o_result   = '0;
        case (i_res_op)
            MUL:                 o_result = w_prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: o_result = w_prod_fix[2*XLEN-1:XLEN];
            // Divide by zero returns all ones regardless of dividend sign.
            DIV, DIVU:           o_result = i_res_b_zero ? '1 :
                                            (w_neg ? (-i_lo) : i_lo);
            // Remainder follows the dividend sign; with a zero divisor the
            // remainder register holds |a|, so this reproduces a.
            REM, REMU:           o_result = i_res_sign_a ? (-i_hi) : i_hi;
            default:             o_result = '0;
        endcase
    end

endmodule : muldiv_sign_fix
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative RV32M execute unit. One shift-add multiply or
//             restoring divide at a time, one bit per cycle over XLEN
//             cycles, with busy_o stalling the pipeline meanwhile.
//  Ports    : clk      clock
//             rst_n    synchronous active-low reset
//             bus      muldiv_if.slave request / response bundle
//  Options  : MULDIV_EARLY_OUT_EN  when defined, divide by zero, signed
//             overflow and multiply by zero go straight IDLE -> DONE.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = c_XLEN_DEFAULT,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic      clk,
    input  logic      rst_n,
    muldiv_if.slave   bus
);

    muldiv_state_e      r_state;
    muldiv_state_e      w_state_nxt;
    muldiv_op_e         r_op;
    muldiv_op_e         w_op_in;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_b_zero;
    logic [XLEN-1:0]    r_hi;      // product high half / partial remainder
    logic [XLEN-1:0]    r_lo;      // multiplier / dividend -> quotient
    logic [XLEN-1:0]    r_mag_b;
    logic [XLEN-1:0]    r_result;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_sign_a;
    logic               w_sign_b;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic [XLEN-1:0]    w_result;
    logic               w_b_zero;
    logic               w_early;
    logic [XLEN-1:0]    w_hi_init;
    logic [XLEN-1:0]    w_lo_init;
    logic [XLEN:0]      w_mul_sum;
    logic [XLEN:0]      w_div_shift;
    logic [XLEN:0]      w_div_diff;
    logic               w_accept;
    logic               w_ready;
    logic               w_busy;
    logic               w_done;

    assign w_op_in  = muldiv_op_e'(bus.funct3_i);
    assign w_b_zero = (bus.b_i == '0);

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .i_op         (w_op_in),
        .i_a          (bus.a_i),
        .i_b          (bus.b_i),
        .o_sign_a     (w_sign_a),
        .o_sign_b     (w_sign_b),
        .o_mag_a      (w_mag_a),
        .o_mag_b      (w_mag_b),
        .i_res_op     (r_op),
        .i_res_sign_a (r_sign_a),
        .i_res_sign_b (r_sign_b),
        .i_res_b_zero (r_b_zero),
        .i_hi         (r_hi),
        .i_lo         (r_lo),
        .o_result     (w_result)
    );

`ifdef MULDIV_EARLY_OUT_EN
    logic w_is_mul;
    logic w_a_zero;
    logic w_ovf;

    // Special cases preload the datapath with its final contents so the
    // DONE-state result selection is identical to the iterated path.
    always_comb begin
        w_is_mul  = ~bus.funct3_i[2];
        w_a_zero  = (bus.a_i == '0);
        w_ovf     = ((w_op_in == DIV) || (w_op_in == REM)) &&
                    (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b_i == '1);
        w_early   = w_is_mul ? (w_a_zero | w_b_zero) : (w_b_zero | w_ovf);
        w_hi_init = '0;
        w_lo_init = w_mag_a;
        if (w_is_mul && (w_a_zero || w_b_zero)) begin
            w_lo_init = '0;
        end else if (!w_is_mul && w_b_zero) begin
            w_hi_init = w_mag_a;
            w_lo_init = '1;
        end
        // Signed overflow: |a| = 2^(XLEN-1) with divisor 1 is already the
        // final quotient in r_lo and zero remainder in r_hi.
    end
`else
    assign w_early   = 1'b0;
    assign w_hi_init = '0;
    assign w_lo_init = w_mag_a;
`endif

    // One multiply step: conditional add then shift the 2*XLEN pair right.
    assign w_mul_sum   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_mag_b}) : {1'b0, r_hi};
    // One restoring-divide step: shift in the next dividend bit, trial subtract.
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};

    assign w_accept = (r_state == IDLE) && bus.start_i && !bus.flush_i;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.start_i && !bus.flush_i) begin
                    w_state_nxt = w_early ? DONE : CALC;
                end
            end
            CALC: begin
                w_busy = 1'b1;
                if (bus.flush_i) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_done      = !bus.flush_i;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= MUL;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mag_b  <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op     <= w_op_in;
                r_sign_a <= w_sign_a;
                r_sign_b <= w_sign_b;
                r_b_zero <= w_b_zero;
                r_mag_b  <= w_mag_b;
                r_hi     <= w_hi_init;
                r_lo     <= w_lo_init;
                r_cnt    <= CNT_W'(XLEN-1);
            end else if (r_state == CALC) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                if (!r_op[2]) begin
                    r_hi <= w_mul_sum[XLEN:1];
                    r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                end else if (!w_div_diff[XLEN]) begin
                    r_hi <= w_div_diff[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b1};
                end else begin
                    r_hi <= w_div_shift[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b0};
                end
            end
            if (w_done) begin
                r_result <= w_result;
            end
        end
    end

    // The fresh result is forwarded during the DONE cycle and captured for
    // holding afterwards; a flushed DONE leaves the held value untouched.
    assign bus.ready_o  = w_ready;
    assign bus.busy_o   = w_busy;
    assign bus.done_o   = w_done;
    assign bus.result_o = w_done ? w_result : r_result;

endmodule : muldiv_unit
`default_nettype wire
